// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a 1-cycle synchronous ROM.
// Presents one instruction per cycle to the FD latch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INSN = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_q,
    output logic [31:0] fd_pc_plus_1,
    output logic [31:0] fd_insn,
    output logic        fd_valid,
    output logic [31:0] pc
);

    logic [31:0] p;
    logic [31:0] f;
    logic        v;
    logic [31:0] h;
    logic        k;

    always_ff @(posedge clock) begin
        if (reset) begin
            p <= RESET_PC;
            f <= 32'h0;
            v <= 1'b0;
            h <= 32'h0;
            k <= 1'b0;
        end else if (redirect) begin
            p <= redirect_pc;
            v <= 1'b0;
            k <= 1'b0;
        end else if (stall) begin
            // ROM output moves on during a stall, so capture it once
            if (!k) begin
                h <= imem_q;
                k <= 1'b1;
            end
        end else begin
            p <= p + 32'h1;
            f <= p;
            v <= 1'b1;
            k <= 1'b0;
        end
    end

    always_comb begin
        imem_addr = p[11:0];
        pc        = p;
    end

    always_comb begin
        fd_insn = NOP_INSN;
        if (v) begin
            fd_insn = k ? h : imem_q;
        end
    end

    always_comb begin
        fd_pc_plus_1 = v ? f + 32'h1 : 32'h0;
        fd_valid     = v & ~redirect;
    end

endmodule
